multi_desk_client_queue: RTL and testbench

// Parametrised successor of the single-counter ClientService ticket block.
// - Issues numbered tickets on btnNew and holds waiting clients in a FIFO-ordered count.
// - Dispatches waiting clients to DESKS independent service desks, each freed by its own btnDone bit.
// - Sits between debounced front-panel buttons and the display and status logic.

---
 rtl/client_queue_pkg.sv | 15 +
 rtl/btn_edge_detect.sv | 29 ++
 rtl/multi_desk_client_queue.sv | 125 ++++++++++++
 tb/tb_multi_desk_client_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/client_queue_pkg.sv
// Shared definitions for the multi-desk client queue: the idle ticket value,
// the wrapping ticket increment and the desk grant index type.
package client_queue_pkg;

    localparam int unsigned IDLE_TICKET = 0;

    // Wide enough to index up to 8 desks.
    typedef logic [2:0] grant_idx_t;

    // Ticket 0 is reserved for "desk idle", so numbering wraps from max back to 1.
    function automatic int unsigned next_ticket(input int unsigned t, input int unsigned max);
        return (t == max) ? 32'd1 : t + 32'd1;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registers a bank of debounced buttons once and flags the cycle after each
// sampled rising edge, so a held button yields a single event.
module btn_edge_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] sample_q;
    logic [W-1:0] prev_q;

    // NOTE: sequential state uses nonblocking assignments so every register
    // sees the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sample_q <= '0;
            prev_q   <= '0;
        end else begin
            sample_q <= btn_i;
            prev_q   <= sample_q;
        end
    end

    assign rise_o = sample_q & ~prev_q;

endmodule

// File: rtl/multi_desk_client_queue.sv
// Ticket dispenser feeding DESKS service desks: issues wrapping ticket numbers,
// counts waiting clients and hands the oldest one to the lowest requesting desk.
module multi_desk_client_queue
    import client_queue_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DESKS      = 2,
    parameter int CAPACITY   = 16,
    parameter int MAX_TICKET = 99
) (
    input  logic                             clk,
    input  logic                             btnReset,
    input  logic                             btnNew,
    input  logic [DESKS-1:0]                 btnDone,
    output logic [DESKS*WIDTH-1:0]           current_client,
    output logic [WIDTH-1:0]                 total_clients,
    output logic [$clog2(CAPACITY+1)-1:0]    waiting,
    output logic                             full,
    output logic                             empty,
    output logic                             reject,
    output logic [DESKS-1:0]                 call_pulse
);

    localparam int WAIT_W = $clog2(CAPACITY + 1);
    localparam logic [WAIT_W-1:0] CAP_W = WAIT_W'(CAPACITY);

    logic              new_evt;
    logic [DESKS-1:0]  done_evt;

    logic [DESKS-1:0]  pending_q, pending_d, req;
    logic [WIDTH-1:0]  last_issued_q, next_serve_q, total_q;
    logic [WAIT_W-1:0] waiting_q;
    logic [WIDTH-1:0]  cur_q [DESKS];
    logic              reject_q;
    logic [DESKS-1:0]  call_q;

    logic              grant_valid;
    grant_idx_t        grant_idx;
    logic              from_queue;
    logic              accept;
    logic              served;
    logic [WIDTH-1:0]  new_ticket;
    logic [WIDTH-1:0]  serve_next;

    btn_edge_detect #(.W(1)) u_new_edge (
        .clk    (clk),
        .rst_i  (btnReset),
        .btn_i  (btnNew),
        .rise_o (new_evt)
    );

    btn_edge_detect #(.W(DESKS)) u_done_edge (
        .clk    (clk),
        .rst_i  (btnReset),
        .btn_i  (btnDone),
        .rise_o (done_evt)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        req         = pending_q | done_evt;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int d = DESKS - 1; d >= 0; d--) begin
            if (req[d]) begin
                grant_valid = 1'b1;
                grant_idx   = grant_idx_t'(d);
            end
        end
        pending_d = req;
        for (int d = 0; d < DESKS; d++) begin
            if (grant_valid && grant_idx == grant_idx_t'(d)) pending_d[d] = 1'b0;
        end
        // A grant that drains the queue frees a slot for a same-cycle arrival.
        from_queue = grant_valid && (waiting_q != '0);
        accept     = new_evt && ((waiting_q < CAP_W) || from_queue);
        served     = grant_valid && (from_queue || accept);
        new_ticket = WIDTH'(next_ticket(32'(last_issued_q), MAX_TICKET));
        serve_next = WIDTH'(next_ticket(32'(next_serve_q), MAX_TICKET));
    end

    always_ff @(posedge clk) begin
        if (btnReset) begin
            pending_q     <= '0;
            last_issued_q <= '0;
            next_serve_q  <= WIDTH'(1);
            total_q       <= '0;
            waiting_q     <= '0;
            reject_q      <= 1'b0;
            call_q        <= '0;
            for (int d = 0; d < DESKS; d++) cur_q[d] <= WIDTH'(IDLE_TICKET);
        end else begin
            pending_q <= pending_d;
            reject_q  <= new_evt && !accept;
            call_q    <= '0;
            if (accept) begin
                last_issued_q <= new_ticket;
                if (total_q != '1) total_q <= total_q + WIDTH'(1);
            end
            if (served) next_serve_q <= serve_next;
            if (accept && !served) waiting_q <= waiting_q + WAIT_W'(1);
            else if (!accept && served) waiting_q <= waiting_q - WAIT_W'(1);
            for (int d = 0; d < DESKS; d++) begin
                if (grant_valid && grant_idx == grant_idx_t'(d)) begin
                    if (from_queue)  cur_q[d] <= next_serve_q;
                    else if (accept) cur_q[d] <= new_ticket;
                    else             cur_q[d] <= WIDTH'(IDLE_TICKET);
                    call_q[d] <= served;
                end
            end
        end
    end

    for (genvar d = 0; d < DESKS; d++) begin : g_desk
        assign current_client[d*WIDTH +: WIDTH] = cur_q[d];
    end

    assign total_clients = total_q;
    assign waiting       = waiting_q;
    assign full          = (waiting_q == CAP_W);
    assign empty         = (waiting_q == '0);
    assign reject        = reject_q;
    assign call_pulse    = call_q;

endmodule

// File: tb/tb_multi_desk_client_queue.sv
// Directed and randomized bench for multi_desk_client_queue (2 desks, capacity 4,
// tickets 1..7) against a queue-of-tickets reference model.
module tb_multi_desk_client_queue;

    localparam int CAP  = 4;
    localparam int MAXT = 7;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        btn_reset = 1'b1;
    logic        btn_new   = 1'b0;
    logic [1:0]  btn_done  = 2'b00;
    logic [15:0] current_client;
    logic [7:0]  total_clients;
    logic [2:0]  waiting;
    logic        full, empty, reject;
    logic [1:0]  call_pulse;

    logic        btn_reset2 = 1'b1;
    logic        btn_new2   = 1'b0;
    logic [1:0]  btn_done2  = 2'b00;
    logic [7:0]  current_client2;
    logic [3:0]  total_clients2;
    logic [4:0]  waiting2;
    logic        full2, empty2, reject2;
    logic [1:0]  call_pulse2;

    multi_desk_client_queue #(.WIDTH(8), .DESKS(2), .CAPACITY(CAP), .MAX_TICKET(MAXT)) dut (
        .clk            (clk),
        .btnReset       (btn_reset),
        .btnNew         (btn_new),
        .btnDone        (btn_done),
        .current_client (current_client),
        .total_clients  (total_clients),
        .waiting        (waiting),
        .full           (full),
        .empty          (empty),
        .reject         (reject),
        .call_pulse     (call_pulse)
    );

    multi_desk_client_queue #(.WIDTH(4), .DESKS(2), .CAPACITY(31), .MAX_TICKET(MAXT)) dut_narrow (
        .clk            (clk),
        .btnReset       (btn_reset2),
        .btnNew         (btn_new2),
        .btnDone        (btn_done2),
        .current_client (current_client2),
        .total_clients  (total_clients2),
        .waiting        (waiting2),
        .full           (full2),
        .empty          (empty2),
        .reject         (reject2),
        .call_pulse     (call_pulse2)
    );

    int n_vec = 0;
    int n_err = 0;
    int rej_seen = 0;

    // Reference model: the waiting line is literally a queue of ticket numbers.
    int   q[$];
    int   last_t, total;
    int   cur[2];
    bit   [1:0] pend, m_call;
    bit   m_rej;
    // Button history as seen by the design (one sampling stage plus the previous sample).
    bit   sn, pn;
    bit   [1:0] sd, pd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_t = 0; total = 0; cur[0] = 0; cur[1] = 0;
        pend = '0; m_call = '0; m_rej = 1'b0;
        sn = 1'b0; pn = 1'b0; sd = '0; pd = '0;
    endtask

    task automatic compare_all();
        check("cur0",    32'(current_client[7:0]),  cur[0]);
        check("cur1",    32'(current_client[15:8]), cur[1]);
        check("total",   32'(total_clients),        total);
        check("waiting", 32'(waiting),              q.size());
        check("full",    32'(full),                 (q.size() == CAP) ? 1 : 0);
        check("empty",   32'(empty),                (q.size() == 0) ? 1 : 0);
        check("reject",  32'(reject),               32'(m_rej));
        check("call",    32'(call_pulse),           32'(m_call));
    endtask

    // Advance one clock: predict the state after the coming edge, then compare.
    task automatic tick();
        bit       en, has, acc;
        bit [1:0] ed, req;
        int       g;
        if (btn_reset) begin
            model_reset();
        end else begin
            en  = sn & ~pn;
            ed  = sd & ~pd;
            req = pend | ed;
            has = (req != 0);
            g   = req[0] ? 0 : 1;
            acc = en && (q.size() < CAP || (has && q.size() > 0));
            m_rej  = en && !acc;
            m_call = '0;
            if (acc) begin
                last_t = (last_t == MAXT) ? 1 : last_t + 1;
                if (total < 255) total++;
                q.push_back(last_t);
            end
            if (has) begin
                if (q.size() > 0) begin
                    cur[g] = q.pop_front();
                    m_call[g] = 1'b1;
                end else begin
                    cur[g] = 0;
                end
                pend = req;
                pend[g] = 1'b0;
            end else begin
                pend = req;
            end
            pn = sn; sn = btn_new;
            pd = sd; sd = btn_done;
        end
        @(posedge clk);
        #1;
        if (reject === 1'b1) rej_seen++;
        compare_all();
    endtask

    task automatic press_new();
        btn_new = 1'b1; tick();
        btn_new = 1'b0; tick();
    endtask

    task automatic press_done(input logic [1:0] mask);
        btn_done = mask; tick();
        btn_done = 2'b00; tick();
    endtask

    task automatic do_reset();
        btn_reset = 1'b1; tick();
        btn_reset = 1'b0; tick();
    endtask

    initial begin
        model_reset();
        // Reset state
        tick(); tick();
        btn_reset2 = 1'b0;
        btn_reset  = 1'b0;
        tick();
        check("rst_total", 32'(total_clients), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full), 0);

        // Three tickets then desk 0 serves the first
        for (int i = 0; i < 3; i++) press_new();
        check("t1_total",   32'(total_clients), 3);
        check("t1_waiting", 32'(waiting), 3);
        press_done(2'b01);
        check("t1_cur0",    32'(current_client[7:0]), 1);
        check("t1_wait2",   32'(waiting), 2);

        // Overfill from empty: 4 accepted, 2 rejected
        do_reset();
        rej_seen = 0;
        for (int i = 0; i < 6; i++) press_new();
        check("t2_total",   32'(total_clients), 4);
        check("t2_full",    32'(full), 1);
        check("t2_rejects", 32'(rej_seen), 2);

        // Held button issues exactly one ticket
        do_reset();
        btn_new = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        btn_new = 1'b0; tick();
        check("t3_total", 32'(total_clients), 1);

        // Two desks request together: desk 0 first, desk 1 next cycle
        do_reset();
        press_new(); press_new();
        btn_done = 2'b11; tick();
        btn_done = 2'b00; tick();
        check("t4_cur0",  32'(current_client[7:0]), 1);
        check("t4_call0", 32'(call_pulse), 32'b01);
        tick();
        check("t4_cur1",  32'(current_client[15:8]), 2);
        check("t4_call1", 32'(call_pulse), 32'b10);

        // Ticket numbering wraps 7 -> 1
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            press_new();
            press_done(2'b01);
            if (i == 7) check("t5_seven", 32'(current_client[7:0]), 7);
            if (i == 8) check("t5_wrap",  32'(current_client[7:0]), 1);
        end

        // Reset mid-operation discards everything
        do_reset();
        for (int i = 0; i < 4; i++) press_new();
        press_done(2'b01);
        check("t6_wait3", 32'(waiting), 3);
        btn_reset = 1'b1; tick();
        btn_reset = 1'b0;
        check("t6_cur",   32'(current_client), 0);
        check("t6_total", 32'(total_clients), 0);
        check("t6_empty", 32'(empty), 1);
        tick();
        press_new();
        press_done(2'b10);
        check("t6_cur1",  32'(current_client[15:8]), 1);

        // Narrow instance: total saturates at 15
        for (int i = 0; i < 20; i++) begin
            btn_new2 = 1'b1; tick();
            btn_new2 = 1'b0; tick();
        end
        check("sat_total",   32'(total_clients2), 15);
        check("sat_waiting", 32'(waiting2), 20);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 600; i++) begin
            btn_new   = ($urandom_range(0, 2) == 0);
            btn_done  = 2'($urandom_range(0, 3));
            btn_reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        btn_reset = 1'b0; btn_new = 1'b0; btn_done = 2'b00;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
